range_list_producer: RTL and testbench

- Producer (responder) end of the req/ack/eol list-stream protocol used by generated function blocks.
- When `ready` is asserted, it latches `lo` and `hi`.
- It then serves the elements lo, lo+STEP, … ≤ hi, one per consumer request, and finishes with a single end-of-list acknowledge.
- It sits behind any list consumer, e.g. a test driver or a fold/map block, that issues `req` and waits for `ack`.

---
 rtl/range_list_producer_pkg.sv | 12 +
 rtl/range_list_producer.sv | 93 +++++++++
 tb/tb_range_list_producer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_list_producer_pkg.sv
// Shared definitions for req/ack/eol list-stream producers and consumers.
// Other list blocks import this to agree on the handshake state encoding.
package range_list_producer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ACK      = 2'd2,
    ST_FINISHED = 2'd3
  } list_state_t;

endpackage

// File: rtl/range_list_producer.sv
// Responder end of the req/ack/eol list stream: serves lo, lo+STEP, ... <= hi
// one element per request, then a single end-of-list acknowledge.
module range_list_producer
  import range_list_producer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             ready,
  output logic             done,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             req,
  output logic             ack,
  output logic             eol,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH:0] STEP_INC = (WIDTH+1)'(STEP);

  list_state_t      state;
  // One spare bit so hi = all-ones terminates instead of wrapping to zero.
  logic [WIDTH:0]   cur;
  logic [WIDTH-1:0] lim;
  logic             eol_flag;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cur      <= '0;
      lim      <= '0;
      eol_flag <= 1'b0;
      ack      <= 1'b0;
      eol      <= 1'b0;
      value    <= '0;
      done     <= 1'b0;
    end else if (!ready) begin
      state    <= ST_IDLE;
      eol_flag <= 1'b0;
      ack      <= 1'b0;
      eol      <= 1'b0;
      value    <= '0;
      done     <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          cur      <= {1'b0, lo};
          lim      <= hi;
          eol_flag <= 1'b0;
          state    <= ST_ARMED;
        end
        ST_ARMED: begin
          if (req) begin
            ack   <= 1'b1;
            state <= ST_ACK;
            if (cur <= {1'b0, lim}) begin
              value <= cur[WIDTH-1:0];
              eol   <= 1'b0;
              cur   <= cur + STEP_INC;
            end else begin
              value    <= '0;
              eol      <= 1'b1;
              eol_flag <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          // Requests seen here are ignored so a slow consumer cannot double-fire.
          if (eol_flag) begin
            state <= ST_FINISHED;
            done  <= 1'b1;
          end else begin
            state <= ST_ARMED;
          end
        end
        ST_FINISHED: begin
          done <= 1'b1;
          if (req) begin
            ack   <= 1'b1;
            eol   <= 1'b1;
            value <= '0;
            state <= ST_ACK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_list_producer.sv
// Randomized scoreboard bench for range_list_producer: a list model pushes the
// expected response per request, a negedge monitor pops and compares each ack.
module tb_range_list_producer;

  localparam int WIDTH = 8;
  localparam int STEP  = 1;

  typedef struct packed {
    logic             eol;
    logic [WIDTH-1:0] value;
  } resp_t;

  logic             CLOCK_50 = 1'b0;
  logic             reset_n;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             req;
  logic             ack;
  logic             eol;
  logic [WIDTH-1:0] value;

  range_list_producer #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .ready    (ready),
    .done     (done),
    .lo       (lo),
    .hi       (hi),
    .req      (req),
    .ack      (ack),
    .eol      (eol),
    .value    (value)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  resp_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cycle    = 0;
  bit    prev_ack = 1'b0;
  int    m_cur;
  int    m_hi;

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    resp_t e;
    cycle++;
    if (ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_ack actual value=%0d eol=%0b required no ack", value, eol);
      end else begin
        e = exp_q.pop_front();
        if (eol !== e.eol || value !== e.value) begin
          failures++;
          $display("[TB] FAIL ack_payload actual value=%0d eol=%0b required value=%0d eol=%0b",
                   value, eol, e.value, e.eol);
        end
      end
      if (prev_ack) begin
        checks++;
        failures++;
        $display("[TB] FAIL ack_width actual=2+ cycles required=1 cycle");
      end
    end
    prev_ack = (ack === 1'b1);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  // The list as a consumer sees it: lo, lo+STEP, ... <= hi, then eol forever.
  function automatic void push_expected();
    if (m_cur <= m_hi) begin
      exp_q.push_back({1'b0, WIDTH'(m_cur)});
      m_cur += STEP;
    end else begin
      exp_q.push_back({1'b1, {WIDTH{1'b0}}});
    end
  endfunction

  task automatic wait_ack(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      n++;
      if (ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("ack_timeout", 0, 1);
  endtask

  task automatic apply_stimulus_start(input int l, input int h);
    @(posedge CLOCK_50); #1;
    lo    = WIDTH'(l);
    hi    = WIDTH'(h);
    ready = 1'b1;
    m_cur = l;
    m_hi  = h;
    @(posedge CLOCK_50); #1;
    lo = WIDTH'($urandom);
    hi = WIDTH'($urandom);
  endtask

  task automatic apply_stimulus_stop();
    @(posedge CLOCK_50); #1;
    ready = 1'b0;
    @(posedge CLOCK_50); #1;
    check_output("abort_done", 32'(done), 0);
  endtask

  task automatic do_request(input int idle_cycles, output bit was_eol);
    int n;
    bit ok;
    if (idle_cycles > 0) begin
      repeat (idle_cycles) @(posedge CLOCK_50);
      #1;
    end
    push_expected();
    req = 1'b1;
    wait_ack(n, ok);
    if (ok) check_output("ack_latency", 32'(n), 2);
    was_eol = !ok || (eol === 1'b1);
    @(posedge CLOCK_50); #1;
    req = 1'b0;
    if (ok && was_eol) check_output("done_after_eol", 32'(done), 1);
  endtask

  task automatic run_to_eol(input int max_req, output int n_vals);
    bit e;
    n_vals = 0;
    for (int i = 0; i < max_req; i++) begin
      do_request($urandom_range(0, 2), e);
      if (e) break;
      n_vals++;
    end
  endtask

  task automatic count_acks_idle(input int cycles_n, output int n_acks);
    n_acks = 0;
    req    = 1'b1;
    for (int i = 0; i < cycles_n; i++) begin
      @(negedge CLOCK_50);
      if (ack === 1'b1) n_acks++;
    end
    @(posedge CLOCK_50); #1;
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n_vals;
    int  n;
    bit  ok;
    bit  e;
    int  ack_cycle[5];

    reset_n = 1'b0;
    ready   = 1'b0;
    req     = 1'b0;
    lo      = '0;
    hi      = '0;
    #25;
    check_output("reset_ack", 32'(ack), 0);
    check_output("reset_eol", 32'(eol), 0);
    check_output("reset_value", 32'(value), 0);
    check_output("reset_done", 32'(done), 0);
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;

    // Basic range 10..20.
    apply_stimulus_start(10, 20);
    run_to_eol(20, n_vals);
    check_output("basic_count", 32'(n_vals), 11);
    apply_stimulus_stop();

    // Empty range: immediate eol, then a repeated eol.
    apply_stimulus_start(5, 4);
    do_request(0, e);
    check_output("empty_first_eol", 32'(e), 1);
    do_request(1, e);
    check_output("empty_repeat_eol", 32'(e), 1);
    check_output("empty_done_held", 32'(done), 1);
    apply_stimulus_stop();

    // Top of the value range must not wrap to 0.
    apply_stimulus_start(253, 255);
    run_to_eol(8, n_vals);
    check_output("wrap_count", 32'(n_vals), 3);
    apply_stimulus_stop();

    // Held req: acks every other cycle.
    apply_stimulus_start(30, 40);
    for (int i = 0; i < 5; i++) push_expected();
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_ack(n, ok);
      ack_cycle[i] = cycle;
    end
    @(posedge CLOCK_50); #1;
    req = 1'b0;
    for (int i = 1; i < 5; i++) check_output("held_spacing", 32'(ack_cycle[i] - ack_cycle[i-1]), 2);
    apply_stimulus_stop();

    // Abort mid-list, ignore req while not ready, restart at 50.
    apply_stimulus_start(0, 100);
    for (int i = 0; i < 3; i++) do_request($urandom_range(0, 2), e);
    apply_stimulus_stop();
    count_acks_idle(5, n);
    check_output("abort_no_ack", 32'(n), 0);
    apply_stimulus_start(50, 60);
    do_request(0, e);
    apply_stimulus_stop();

    // req already high when ready rises.
    @(posedge CLOCK_50); #1;
    lo    = 8'd77;
    hi    = 8'd80;
    m_cur = 77;
    m_hi  = 80;
    push_expected();
    ready = 1'b1;
    req   = 1'b1;
    wait_ack(n, ok);
    check_output("early_req_latency", 32'(n), 3);
    @(posedge CLOCK_50); #1;
    req = 1'b0;
    apply_stimulus_stop();

    // Async reset during the ack cycle.
    apply_stimulus_start(7, 50);
    push_expected();
    req = 1'b1;
    wait_ack(n, ok);
    #1;
    reset_n = 1'b0;
    ready   = 1'b0;
    req     = 1'b0;
    #1;
    check_output("midreset_ack", 32'(ack), 0);
    check_output("midreset_eol", 32'(eol), 0);
    check_output("midreset_value", 32'(value), 0);
    check_output("midreset_done", 32'(done), 0);
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    count_acks_idle(4, n);
    check_output("post_reset_no_ack", 32'(n), 0);
    apply_stimulus_start(3, 5);
    run_to_eol(8, n_vals);
    check_output("post_reset_count", 32'(n_vals), 3);
    apply_stimulus_stop();

    // Randomized lists with random consumer pacing and random aborts.
    for (int t = 0; t < 10; t++) begin
      int l;
      int h;
      int abort_at;
      l = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) h = (l > 0) ? l - 1 : 0;
      else                           h = (l + $urandom_range(0, 6) > 255) ? 255 : l + $urandom_range(0, 6);
      abort_at = $urandom_range(2, 12);
      apply_stimulus_start(l, h);
      for (int i = 0; i < abort_at; i++) begin
        do_request($urandom_range(0, 2), e);
        if (e && $urandom_range(0, 1) == 0) break;
      end
      apply_stimulus_stop();
    end

    repeat (3) @(posedge CLOCK_50);
    check_output("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
